// File: rtl/mem_sized_if.sv
// Request/completion bus for the sized unified memory.
// The core side drives the request fields; the memory returns ready/err/busy/rdata.
interface mem_sized_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic        ready;
    logic        err;
    logic        busy;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, size, uns,
        input  ready, err, busy, rdata
    );

    modport slave (
        input  req, we, addr, wdata, size, uns,
        output ready, err, busy, rdata
    );
endinterface

// File: rtl/mem_sized.sv
// Unified I/D memory with byte/half/word lanes and a fixed wait-state count.
// Misaligned or reserved-size accesses complete normally but flag err.
module mem_sized #(
    parameter int    ADDR_W    = 12,
    parameter int    LATENCY   = 2,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_sized_if.slave  bus
);
    localparam int DEPTH = 2 ** (ADDR_W - 2);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    logic [31:0] r_mem [DEPTH];

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [1:0]        r_size;
    logic              r_uns;
    logic              r_ready;
    logic              r_err;
    logic              r_busy;
    logic [31:0]       r_rdata;

    logic              w_mis;
    logic [3:0]        w_be;
    logic [31:0]       w_wd;
    logic [ADDR_W-3:0] w_idx;
    logic [31:0]       w_word;
    logic [7:0]        w_b;
    logic [15:0]       w_h;
    logic [31:0]       w_ld;
    logic              w_unused;

    // Upper address bits alias by design.
    assign w_unused = &{1'b0, bus.addr[31:ADDR_W]};

    assign w_idx  = r_addr[ADDR_W-1:2];
    assign w_word = r_mem[w_idx];
    assign w_b    = w_word[{r_addr[1:0], 3'b000} +: 8];
    assign w_h    = r_addr[1] ? w_word[31:16] : w_word[15:0];

    assign w_mis = (r_size == 2'b11)
                 | ((r_size == 2'b01) & r_addr[0])
                 | ((r_size == 2'b10) & (r_addr[1:0] != 2'b00));

    always_comb begin
        w_be = 4'b0000;
        w_wd = r_wdata;
        w_ld = w_word;
        unique case (r_size)
            2'b00: begin
                w_be = 4'b0001 << r_addr[1:0];
                w_wd = {4{r_wdata[7:0]}};
                w_ld = {{24{~r_uns & w_b[7]}}, w_b};
            end
            2'b01: begin
                w_be = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wd = {2{r_wdata[15:0]}};
                w_ld = {{16{~r_uns & w_h[15]}}, w_h};
            end
            2'b10: begin
                w_be = 4'b1111;
            end
            default: begin
                w_be = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (r_state == S_DONE && r_we && !w_mis) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
            r_size  <= 2'b00;
            r_uns   <= 1'b0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.req) begin
                        r_we    <= bus.we;
                        r_addr  <= bus.addr[ADDR_W-1:0];
                        r_wdata <= bus.wdata;
                        r_size  <= bus.size;
                        r_uns   <= bus.uns;
                        r_busy  <= 1'b1;
                        r_cnt   <= LAT_M1;
                        r_state <= (LATENCY == 0) ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) r_state <= S_DONE;
                    else               r_cnt   <= r_cnt - 4'd1;
                end
                S_DONE: begin
                    r_ready <= 1'b1;
                    r_err   <= w_mis;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                    if (!w_mis && !r_we) r_rdata <= w_ld;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ready = r_ready;
    assign bus.err   = r_err;
    assign bus.busy  = r_busy;
    assign bus.rdata = r_rdata;
endmodule

// File: tb/tb_mem_sized.sv
// Scoreboard bench: one instance with two wait states, one with none.
// Expected completions are queued at issue and checked when ready pulses.
module tb_mem_sized;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        req, we, uns;
    logic [31:0] addr, wdata;
    logic [1:0]  size;
    logic        ready, err, busy;
    logic [31:0] rdata;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int bcnt   = 0;
    logic [31:0] last_rd [2];

    typedef struct {
        logic        err;
        logic [31:0] rd;
        int          due;
        int          lat;
        string       tag;
    } exp_t;

    exp_t q[$];

    mem_sized_if bus2 ();
    mem_sized_if bus0 ();

    assign bus2.req   = req & ~sel;
    assign bus0.req   = req & sel;
    assign bus2.we    = we;
    assign bus0.we    = we;
    assign bus2.addr  = addr;
    assign bus0.addr  = addr;
    assign bus2.wdata = wdata;
    assign bus0.wdata = wdata;
    assign bus2.size  = size;
    assign bus0.size  = size;
    assign bus2.uns   = uns;
    assign bus0.uns   = uns;

    assign ready = sel ? bus0.ready : bus2.ready;
    assign err   = sel ? bus0.err   : bus2.err;
    assign busy  = sel ? bus0.busy  : bus2.busy;
    assign rdata = sel ? bus0.rdata : bus2.rdata;

    mem_sized #(.ADDR_W(12), .LATENCY(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    mem_sized #(.ADDR_W(12), .LATENCY(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (busy) bcnt++;
        if (ready) begin
            if (q.size() == 0) begin
                check("spurious_ready", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check({e.tag, "_err"}, 32'(err), 32'(e.err));
                check({e.tag, "_rdata"}, rdata, e.rd);
                check({e.tag, "_lat"}, 32'(cyc), 32'(e.due));
                check({e.tag, "_busy"}, 32'(bcnt), 32'(e.lat + 1));
            end
            bcnt = 0;
        end
    end

    task automatic access(input string tag, input logic w,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] sz, input logic u,
                          input logic e_err, input logic [31:0] e_rd,
                          input bit pulse);
        exp_t x;
        int   lat;
        bit   done;
        lat   = sel ? 0 : 2;
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        size  = sz;
        uns   = u;
        if (!(e_err || w)) last_rd[sel] = e_rd;
        x.err = e_err;
        x.rd  = last_rd[sel];
        x.due = cyc + 1 + lat + 1;
        x.lat = lat;
        x.tag = tag;
        q.push_back(x);
        @(posedge clk);
        #1;
        req   = 1'b0;
        we    = ~w;
        addr  = ~a;
        wdata = ~d;
        size  = ~sz;
        uns   = ~u;
        done  = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            req = (pulse && n == lat + 1);
            if (ready) begin
                done = 1'b1;
                break;
            end
        end
        req = 1'b0;
        if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        sel   = 1'b0;
        req   = 1'b0;
        we    = 1'b0;
        addr  = 32'd0;
        wdata = 32'd0;
        size  = 2'b00;
        uns   = 1'b0;
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_err",   32'(err),   32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_rdata", rdata,      32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        access("sw_010", 1, 32'h010, 32'hDEADBEEF, 2'b10, 0, 0, 32'h0, 0);
        access("lw_010", 0, 32'h010, 32'h0, 2'b10, 0, 0, 32'hDEADBEEF, 0);

        access("sw_020", 1, 32'h020, 32'h0, 2'b10, 0, 0, 32'h0, 0);
        access("sb_023", 1, 32'h023, 32'hAAAAAA80, 2'b00, 0, 0, 32'h0, 0);
        access("lw_020", 0, 32'h020, 32'h0, 2'b10, 0, 0, 32'h80000000, 0);
        access("lb_023", 0, 32'h023, 32'h0, 2'b00, 0, 0, 32'hFFFFFF80, 0);
        access("lbu_023", 0, 32'h023, 32'h0, 2'b00, 1, 0, 32'h00000080, 0);

        access("sh_022", 1, 32'h022, 32'h55558001, 2'b01, 0, 0, 32'h0, 0);
        access("lh_022", 0, 32'h022, 32'h0, 2'b01, 0, 0, 32'hFFFF8001, 0);
        access("lhu_022", 0, 32'h022, 32'h0, 2'b01, 1, 0, 32'h00008001, 0);
        access("lw_020b", 0, 32'h020, 32'h0, 2'b10, 0, 0, 32'h80010000, 0);

        access("lw_006", 0, 32'h006, 32'h0, 2'b10, 0, 1, 32'h0, 0);
        access("sh_021", 1, 32'h021, 32'hFFFFFFFF, 2'b01, 0, 1, 32'h0, 0);
        access("sz11_010", 1, 32'h010, 32'h0, 2'b11, 0, 1, 32'h0, 0);
        access("lw_020c", 0, 32'h020, 32'h0, 2'b10, 0, 0, 32'h80010000, 0);
        access("lw_010b", 0, 32'h010, 32'h0, 2'b10, 0, 0, 32'hDEADBEEF, 0);
        access("lbu_021", 0, 32'h021, 32'h0, 2'b00, 1, 0, 32'h00000000, 0);

        access("sw_030", 1, 32'h030, 32'hCAFEF00D, 2'b10, 0, 0, 32'h0, 0);
        access("lw_030", 0, 32'h030, 32'h0, 2'b10, 0, 0, 32'hCAFEF00D, 0);

        req   = 1'b1;
        we    = 1'b1;
        addr  = 32'h030;
        wdata = 32'h12345678;
        size  = 2'b10;
        uns   = 1'b0;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(ready), 32'd0);
        check("abort_err",   32'(err),   32'd0);
        check("abort_busy",  32'(busy),  32'd0);
        check("abort_rdata", rdata,      32'd0);
        bcnt = 0;
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        access("lw_030b", 0, 32'h030, 32'h0, 2'b10, 0, 0, 32'hCAFEF00D, 0);

        access("lw_pulse", 0, 32'h010, 32'h0, 2'b10, 0, 0, 32'hDEADBEEF, 1);
        @(negedge clk);
        check("pulse_busy1", 32'(busy), 32'd0);
        @(negedge clk);
        check("pulse_busy2", 32'(busy), 32'd0);

        sel = 1'b1;
        @(negedge clk);
        access("l0_sw_1004", 1, 32'h1004, 32'h0BADC0DE, 2'b10, 0, 0, 32'h0, 0);
        access("l0_lw_004", 0, 32'h004, 32'h0, 2'b10, 0, 0, 32'h0BADC0DE, 0);
        access("l0_lhu_1006", 0, 32'h1006, 32'h0, 2'b01, 1, 0, 32'h00000BAD, 0);
        access("l0_lb_005", 0, 32'h005, 32'h0, 2'b00, 0, 0, 32'hFFFFFFC0, 0);

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
